// File: rtl/dmi_host_seq.sv
// rtl/dmi_host_seq.sv - DMI initiator: host read/write commands to dm::dmi_req_t with busy retry and timeout
//
// Purpose:
//   Accepts single-word read/write commands from a local host port, issues them
//   as DMI requests toward the debug module, and returns the DMI response as a
//   host completion. Busy responses (resp=3) are reissued after a fixed backoff
//   up to MaxRetries times; a missing response ends in a timeout completion.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   host_req_*               host command channel (valid/ready, addr, write, wdata)
//   host_rsp_*               host completion channel (valid/ready, rdata, err)
//   busy_o                   high whenever the sequencer is not idle
//   dmi_req_*                DMI request channel, dmi_req_o = {addr[6:0], op[1:0], data[31:0]}
//   dmi_resp_*               DMI response channel, dmi_resp_i = {data[31:0], resp[1:0]}
//
// Every output is a register, so there is no combinational input-to-output path.

module dmi_host_seq #(
    parameter int unsigned MaxRetries    = 15,
    parameter int unsigned BackoffCycles = 4,
    parameter int unsigned TimeoutCycles = 1023
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        host_req_valid_i,
    output logic        host_req_ready_o,
    input  logic [6:0]  host_addr_i,
    input  logic        host_write_i,
    input  logic [31:0] host_wdata_i,

    output logic        host_rsp_valid_o,
    input  logic        host_rsp_ready_i,
    output logic [31:0] host_rdata_o,
    output logic [1:0]  host_err_o,

    output logic        busy_o,

    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [40:0] dmi_req_o,

    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [33:0] dmi_resp_i
);

    // A timeout of 0 means "disabled"; keep the counter at least one bit wide.
    localparam int unsigned BW = $clog2(BackoffCycles + 1);
    localparam int unsigned TW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);

    localparam logic [1:0] DTM_READ  = 2'd1;
    localparam logic [1:0] DTM_WRITE = 2'd2;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_FAIL    = 2'd1;
    localparam logic [1:0] ERR_RETRIES = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_BACKOFF,
        S_RSP
    } state_t;

    state_t        r_state;
    logic [7:0]    r_retry_cnt;
    logic [BW-1:0] r_backoff_cnt;
    logic [TW-1:0] r_timeout_cnt;

    logic          r_host_req_ready;
    logic          r_host_rsp_valid;
    logic [31:0]   r_host_rdata;
    logic [1:0]    r_host_err;
    logic          r_busy;
    logic          r_dmi_req_valid;
    logic [40:0]   r_dmi_req;
    logic          r_dmi_resp_ready;

    logic [1:0]    w_resp;
    logic [31:0]   w_resp_data;
    logic [TW-1:0] w_timeout_next;
    logic          w_retry_left;

    assign w_resp         = dmi_resp_i[1:0];
    assign w_resp_data    = dmi_resp_i[33:2];
    assign w_timeout_next = r_timeout_cnt + TW'(1);
    assign w_retry_left   = (r_retry_cnt < 8'(MaxRetries));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state          <= S_IDLE;
            r_retry_cnt      <= '0;
            r_backoff_cnt    <= '0;
            r_timeout_cnt    <= '0;
            r_host_req_ready <= 1'b0;
            r_host_rsp_valid <= 1'b0;
            r_host_rdata     <= '0;
            r_host_err       <= '0;
            r_busy           <= 1'b0;
            r_dmi_req_valid  <= 1'b0;
            r_dmi_req        <= '0;
            r_dmi_resp_ready <= 1'b0;
        end else begin
            // Responses are always drained; only WaitResp actually captures one,
            // so stale responses after a timeout or reset fall on the floor.
            r_dmi_resp_ready <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_host_req_ready <= 1'b1;
                    if (host_req_valid_i && r_host_req_ready) begin
                        r_host_req_ready <= 1'b0;
                        r_busy           <= 1'b1;
                        r_dmi_req_valid  <= 1'b1;
                        r_dmi_req        <= {host_addr_i,
                                             (host_write_i ? DTM_WRITE : DTM_READ),
                                             (host_write_i ? host_wdata_i : 32'h0)};
                        r_retry_cnt      <= '0;
                        r_state          <= S_REQ;
                    end
                end

                S_REQ: begin
                    // r_dmi_req is untouched here, which keeps it stable under backpressure
                    // and makes every reissue identical to the first issue.
                    if (dmi_req_ready_i) begin
                        r_dmi_req_valid <= 1'b0;
                        r_timeout_cnt   <= '0;
                        r_state         <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (dmi_resp_valid_i) begin
                        if (w_resp == 2'd3 && w_retry_left) begin
                            r_retry_cnt   <= r_retry_cnt + 8'd1;
                            r_backoff_cnt <= BW'(BackoffCycles);
                            r_state       <= S_BACKOFF;
                        end else begin
                            r_host_rsp_valid <= 1'b1;
                            r_host_rdata     <= w_resp_data;
                            if (w_resp == 2'd0) begin
                                r_host_err <= ERR_OK;
                            end else if (w_resp == 2'd3) begin
                                r_host_err <= ERR_RETRIES;
                            end else begin
                                r_host_err <= ERR_FAIL;
                            end
                            r_state <= S_RSP;
                        end
                    end else if (TimeoutCycles != 0) begin
                        // The counter stops at TimeoutCycles because reaching it leaves the state.
                        r_timeout_cnt <= w_timeout_next;
                        if (w_timeout_next == TW'(TimeoutCycles)) begin
                            r_host_rsp_valid <= 1'b1;
                            r_host_rdata     <= '0;
                            r_host_err       <= ERR_TIMEOUT;
                            r_state          <= S_RSP;
                        end
                    end
                end

                S_BACKOFF: begin
                    // Loaded with BackoffCycles, so exactly that many cycles are spent here.
                    if (r_backoff_cnt <= BW'(1)) begin
                        r_backoff_cnt   <= '0;
                        r_dmi_req_valid <= 1'b1;
                        r_state         <= S_REQ;
                    end else begin
                        r_backoff_cnt <= r_backoff_cnt - BW'(1);
                    end
                end

                S_RSP: begin
                    if (host_rsp_ready_i) begin
                        r_host_rsp_valid <= 1'b0;
                        r_busy           <= 1'b0;
                        r_host_req_ready <= 1'b1;
                        r_state          <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign host_req_ready_o = r_host_req_ready;
    assign host_rsp_valid_o = r_host_rsp_valid;
    assign host_rdata_o     = r_host_rdata;
    assign host_err_o       = r_host_err;
    assign busy_o           = r_busy;
    assign dmi_req_valid_o  = r_dmi_req_valid;
    assign dmi_req_o        = r_dmi_req;
    assign dmi_resp_ready_o = r_dmi_resp_ready;

endmodule

// File: tb/tb_dmi_host_seq.sv
// tb/tb_dmi_host_seq.sv - scoreboard bench for dmi_host_seq (MaxRetries=2, BackoffCycles=4, TimeoutCycles=8)

module tb_dmi_host_seq;

    localparam int unsigned MAX_RETRIES = 2;
    localparam int unsigned BACKOFF     = 4;
    localparam int unsigned TIMEOUT     = 8;

    logic        clk_i;
    logic        rst_i;
    logic        host_req_valid_i;
    logic        host_req_ready_o;
    logic [6:0]  host_addr_i;
    logic        host_write_i;
    logic [31:0] host_wdata_i;
    logic        host_rsp_valid_o;
    logic        host_rsp_ready_i;
    logic [31:0] host_rdata_o;
    logic [1:0]  host_err_o;
    logic        busy_o;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    logic [40:0] dmi_req_o;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;
    logic [33:0] dmi_resp_i;

    dmi_host_seq #(
        .MaxRetries   (MAX_RETRIES),
        .BackoffCycles(BACKOFF),
        .TimeoutCycles(TIMEOUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .host_req_valid_i(host_req_valid_i),
        .host_req_ready_o(host_req_ready_o),
        .host_addr_i     (host_addr_i),
        .host_write_i    (host_write_i),
        .host_wdata_i    (host_wdata_i),
        .host_rsp_valid_o(host_rsp_valid_o),
        .host_rsp_ready_i(host_rsp_ready_i),
        .host_rdata_o    (host_rdata_o),
        .host_err_o      (host_err_o),
        .busy_o          (busy_o),
        .dmi_req_valid_o (dmi_req_valid_o),
        .dmi_req_ready_i (dmi_req_ready_i),
        .dmi_req_o       (dmi_req_o),
        .dmi_resp_valid_i(dmi_resp_valid_i),
        .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmi_resp_i      (dmi_resp_i)
    );

    typedef struct packed {
        logic [40:0] req;
        logic        respond;
        logic [1:0]  resp;
        logic [31:0] data;
    } dmi_ent_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } cpl_t;

    dmi_ent_t    req_q[$];
    cpl_t        rsp_q[$];
    logic [33:0] inject_q[$];
    int          hs_cyc[$];

    int n_checks     = 0;
    int n_errors     = 0;
    int cyc          = 0;
    int hs_cnt       = 0;
    int cpl_cnt      = 0;
    int acc_cyc      = 0;
    int last_cpl_cyc = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s act=event exp=none (cycle %0d)", name, cyc);
    endtask

    task automatic push_dmi(input logic [40:0] req, input logic respond,
                            input logic [1:0] resp, input logic [31:0] data);
        dmi_ent_t e;
        e.req = req; e.respond = respond; e.resp = resp; e.data = data;
        req_q.push_back(e);
    endtask

    task automatic push_cpl(input logic [31:0] rdata, input logic [1:0] err);
        cpl_t c;
        c.rdata = rdata; c.err = err;
        rsp_q.push_back(c);
    endtask

    task automatic host_cmd(input logic [6:0] a, input logic w, input logic [31:0] d);
        int n;
        @(posedge clk_i); #1;
        host_req_valid_i = 1'b1;
        host_addr_i      = a;
        host_write_i     = w;
        host_wdata_i     = d;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!host_req_ready_o && n < 50);
        if (!host_req_ready_o) fail_now("host_accept_timeout");
        acc_cyc = cyc;
        @(posedge clk_i); #1;
        host_req_valid_i = 1'b0;
        host_wdata_i     = 32'h0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while ((rsp_q.size() != 0 || busy_o) && n < 300);
        if (rsp_q.size() != 0 || busy_o) begin
            fail_now("wait_done_timeout");
            rsp_q.delete();
        end
        check("req_q_drained", 64'(req_q.size()), 64'(0));
        req_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_host_req_ready"}, 64'(host_req_ready_o), 64'(0));
        check({tag, "_host_rsp_valid"}, 64'(host_rsp_valid_o), 64'(0));
        check({tag, "_host_rdata"},     64'(host_rdata_o),     64'(0));
        check({tag, "_host_err"},       64'(host_err_o),       64'(0));
        check({tag, "_busy"},           64'(busy_o),           64'(0));
        check({tag, "_dmi_req_valid"},  64'(dmi_req_valid_o),  64'(0));
        check({tag, "_dmi_req"},        64'(dmi_req_o),        64'(0));
        check({tag, "_dmi_resp_ready"}, 64'(dmi_resp_ready_o), 64'(0));
    endtask

    // DMI responder: presents queued responses one per cycle.
    initial begin
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = '0;
        forever begin
            @(posedge clk_i); #1;
            if (inject_q.size() > 0) begin
                dmi_resp_i       = inject_q.pop_front();
                dmi_resp_valid_i = 1'b1;
            end else begin
                dmi_resp_valid_i = 1'b0;
                dmi_resp_i       = '0;
            end
        end
    end

    // Monitor: compares DMI requests and host completions against the queues.
    initial begin : monitor
        dmi_ent_t ent;
        cpl_t     cpl;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (dmi_req_valid_o) begin
                    if (req_q.size() == 0) begin
                        fail_now("dmi_req_unexpected");
                    end else begin
                        check("dmi_req", 64'(dmi_req_o), 64'(req_q[0].req));
                        if (dmi_req_ready_i) begin
                            ent = req_q.pop_front();
                            hs_cnt++;
                            hs_cyc.push_back(cyc);
                            if (ent.respond) inject_q.push_back({ent.data, ent.resp});
                        end
                    end
                end
                if (host_rsp_valid_o) begin
                    if (rsp_q.size() == 0) begin
                        fail_now("cpl_unexpected");
                    end else begin
                        check("cpl_rdata", 64'(host_rdata_o), 64'(rsp_q[0].rdata));
                        check("cpl_err",   64'(host_err_o),   64'(rsp_q[0].err));
                        if (host_rsp_ready_i) begin
                            cpl = rsp_q.pop_front();
                            cpl_cnt++;
                            last_cpl_cyc = cyc;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int cpl_before;
        rst_i            = 1'b1;
        host_req_valid_i = 1'b0;
        host_addr_i      = '0;
        host_write_i     = 1'b0;
        host_wdata_i     = '0;
        host_rsp_ready_i = 1'b1;
        dmi_req_ready_i  = 1'b1;

        // Reset state and release timing.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rel_ready_still_low", 64'(host_req_ready_o), 64'(0));
        @(negedge clk_i);
        check("rel_host_req_ready", 64'(host_req_ready_o), 64'(1));
        check("rel_dmi_resp_ready", 64'(dmi_resp_ready_o), 64'(1));

        // Read, zero-wait DMI; wdata must be ignored.
        push_dmi({7'h11, 2'd1, 32'h0}, 1'b1, 2'd0, 32'h0040_0382);
        push_cpl(32'h0040_0382, 2'd0);
        host_cmd(7'h11, 1'b0, 32'hFFFF_FFFF);
        @(negedge clk_i);
        check("ready_low_after_accept", 64'(host_req_ready_o), 64'(0));
        check("busy_after_accept", 64'(busy_o), 64'(1));
        wait_done();
        check("read_latency", 64'(last_cpl_cyc - acc_cyc), 64'(3));

        // Write with 5 cycles of DMI request backpressure, then host completion backpressure.
        dmi_req_ready_i  = 1'b0;
        host_rsp_ready_i = 1'b0;
        hs_cnt = 0;
        push_dmi({7'h10, 2'd2, 32'h8000_0001}, 1'b1, 2'd0, 32'h0);
        push_cpl(32'h0, 2'd0);
        host_cmd(7'h10, 1'b1, 32'h8000_0001);
        repeat (5) @(posedge clk_i);
        #1;
        dmi_req_ready_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!host_rsp_valid_o && n < 20);
        check("bp_hs_count", 64'(hs_cnt), 64'(1));
        repeat (2) @(negedge clk_i);
        check("bp_rsp_held_valid", 64'(host_rsp_valid_o), 64'(1));
        @(posedge clk_i); #1;
        host_rsp_ready_i = 1'b1;
        wait_done();

        // Two busy responses, then ok: three issues spaced BACKOFF+2 apart.
        hs_cnt = 0;
        hs_cyc.delete();
        push_dmi({7'h04, 2'd1, 32'h0}, 1'b1, 2'd3, 32'h0000_0001);
        push_dmi({7'h04, 2'd1, 32'h0}, 1'b1, 2'd3, 32'h0000_0002);
        push_dmi({7'h04, 2'd1, 32'h0}, 1'b1, 2'd0, 32'hCAFE_F00D);
        push_cpl(32'hCAFE_F00D, 2'd0);
        host_cmd(7'h04, 1'b0, 32'h0);
        wait_done();
        check("retry_hs_count", 64'(hs_cnt), 64'(3));
        if (hs_cyc.size() == 3) begin
            check("retry_gap0", 64'(hs_cyc[1] - hs_cyc[0]), 64'(6));
            check("retry_gap1", 64'(hs_cyc[2] - hs_cyc[1]), 64'(6));
        end
        check("retry_latency", 64'(last_cpl_cyc - acc_cyc), 64'(15));

        // Busy on every issue: MaxRetries=2 allows 3 issues, then err 2 with the last data.
        hs_cnt = 0;
        push_dmi({7'h20, 2'd2, 32'h0000_00AA}, 1'b1, 2'd3, 32'h0000_0001);
        push_dmi({7'h20, 2'd2, 32'h0000_00AA}, 1'b1, 2'd3, 32'h0000_0002);
        push_dmi({7'h20, 2'd2, 32'h0000_00AA}, 1'b1, 2'd3, 32'h0000_BEEF);
        push_cpl(32'h0000_BEEF, 2'd2);
        host_cmd(7'h20, 1'b1, 32'h0000_00AA);
        wait_done();
        check("exhaust_hs_count", 64'(hs_cnt), 64'(3));
        check("exhaust_latency", 64'(last_cpl_cyc - acc_cyc), 64'(15));

        // Failed (resp 2) and reserved (resp 1) both map to err 1.
        push_dmi({7'h17, 2'd2, 32'h0000_005A}, 1'b1, 2'd2, 32'h1234_0002);
        push_cpl(32'h1234_0002, 2'd1);
        host_cmd(7'h17, 1'b1, 32'h0000_005A);
        wait_done();
        push_dmi({7'h38, 2'd1, 32'h0}, 1'b1, 2'd1, 32'h1234_0001);
        push_cpl(32'h1234_0001, 2'd1);
        host_cmd(7'h38, 1'b0, 32'h5555_5555);
        wait_done();

        // Timeout: no response, err 3 after 8 WaitResp cycles; then a stale response is drained.
        push_dmi({7'h11, 2'd1, 32'h0}, 1'b0, 2'd0, 32'h0);
        push_cpl(32'h0, 2'd3);
        host_cmd(7'h11, 1'b0, 32'h0);
        wait_done();
        check("timeout_latency", 64'(last_cpl_cyc - acc_cyc), 64'(10));
        @(posedge clk_i); #1;
        inject_q.push_back({32'h0BAD_0BAD, 2'd0});
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!dmi_resp_valid_i && n < 5);
        check("stale_resp_ready", 64'(dmi_resp_ready_o), 64'(1));
        check("stale_busy", 64'(busy_o), 64'(0));
        @(negedge clk_i);
        check("stale_no_cpl", 64'(host_rsp_valid_o), 64'(0));
        push_dmi({7'h11, 2'd1, 32'h0}, 1'b1, 2'd0, 32'h7654_3210);
        push_cpl(32'h7654_3210, 2'd0);
        host_cmd(7'h11, 1'b0, 32'h0);
        wait_done();

        // Reset during WaitResp: outputs clear, no completion, next command is clean.
        cpl_before = cpl_cnt;
        push_dmi({7'h05, 2'd1, 32'h0}, 1'b0, 2'd0, 32'h0);
        host_cmd(7'h05, 1'b0, 32'h0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("midrst");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("midrst_no_cpl", 64'(cpl_cnt), 64'(cpl_before));
        check("midrst_idle_ready", 64'(host_req_ready_o), 64'(1));
        push_dmi({7'h12, 2'd1, 32'h0}, 1'b1, 2'd0, 32'h1111_2222);
        push_cpl(32'h1111_2222, 2'd0);
        host_cmd(7'h12, 1'b0, 32'h0);
        wait_done();
        check("after_rst_latency", 64'(last_cpl_cyc - acc_cyc), 64'(3));

        repeat (3) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
